// File: rtl/resonant_emu_mc.sv
// Multi-channel resonant-system emulator: each channel turns a latched i_ref into a burst of
// charge pulses. Build with RESONANT_EMU_Q_DROP_EN to model the charge collapse above DROP_THRESHOLD.
module resonant_emu_mc #(
    parameter int NUM_CH         = 1,
    parameter int BUS_WIDTH      = 10,
    parameter int Q_PER_PULSE    = 5,
    parameter int PULSE_DURATION = 3,
    parameter int GAP_CYCLES     = 3,
    parameter int GAIN_NUM       = 1,
    parameter int GAIN_SHIFT     = 0,
    parameter int DROP_THRESHOLD = 900,
    parameter int DROP_PULSES    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CH*BUS_WIDTH-1:0] i_ref,
    output logic [NUM_CH-1:0]           q_serialized,
    output logic [NUM_CH-1:0]           pulses_ended,
    output logic [NUM_CH-1:0]           busy,
    output logic [3*NUM_CH-1:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_PULSE_HI = 3'd2,
        S_PULSE_LO = 3'd3,
        S_END      = 3'd4
    } state_e;

    localparam int PW   = BUS_WIDTH + 32;
    localparam int MAXD = (PULSE_DURATION > GAP_CYCLES) ? PULSE_DURATION : GAP_CYCLES;
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [BUS_WIDTH-1:0] N_MAX = '1;

    // Pulse count for one reference, computed at full product width before saturating.
    function automatic logic [BUS_WIDTH-1:0] calc_n(input logic [BUS_WIDTH-1:0] iref);
        logic [PW-1:0]        q_total;
        logic [PW-1:0]        n_full;
        logic [BUS_WIDTH-1:0] n;
        q_total = (PW'(iref) * PW'(GAIN_NUM)) >> GAIN_SHIFT;
        n_full  = q_total / PW'(Q_PER_PULSE);
        n       = (n_full > PW'(N_MAX)) ? N_MAX : n_full[BUS_WIDTH-1:0];
`ifdef RESONANT_EMU_Q_DROP_EN
        if (PW'(iref) > PW'(DROP_THRESHOLD)) begin
            n = (PW'(n) > PW'(DROP_PULSES)) ? (n - BUS_WIDTH'(DROP_PULSES)) : '0;
        end
`endif
        return n;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e               state_q, state_d;
        logic [BUS_WIDTH-1:0] n_q, n_d;
        logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
        logic [CW-1:0]        cyc_q, cyc_d;
        logic                 q_q, q_d;
        logic                 pe_q, pe_d;
        logic [BUS_WIDTH-1:0] n_load;

        assign n_load = calc_n(i_ref[c*BUS_WIDTH +: BUS_WIDTH]);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
                n_q     <= '0;
                cnt_q   <= '0;
                cyc_q   <= '0;
                q_q     <= 1'b0;
                pe_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                n_q     <= n_d;
                cnt_q   <= cnt_d;
                cyc_q   <= cyc_d;
                q_q     <= q_d;
                pe_q    <= pe_d;
            end
        end

        // Dropping start anywhere inside a burst aborts straight to IDLE without a strobe.
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (!start)                state_d = S_IDLE;
                    else if (n_load == '0)     state_d = S_END;
                    else                       state_d = S_PULSE_HI;
                end
                S_PULSE_HI: begin
                    if (!start)                                 state_d = S_IDLE;
                    else if (cyc_q == CW'(PULSE_DURATION - 1))  state_d = S_PULSE_LO;
                end
                S_PULSE_LO: begin
                    if (!start)                             state_d = S_IDLE;
                    else if (cyc_q == CW'(GAP_CYCLES - 1))  state_d = (cnt_q == n_q) ? S_END : S_PULSE_HI;
                end
                S_END: begin
                    state_d = start ? S_LOAD : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // cnt counts pulses already emitted; it steps as each high phase closes.
        always_comb begin
            n_d   = n_q;
            cnt_d = cnt_q;
            cyc_d = '0;
            if (state_d == S_IDLE) begin
                n_d   = '0;
                cnt_d = '0;
            end else if (state_d == S_LOAD) begin
                cnt_d = '0;
            end else if (state_q == S_LOAD) begin
                n_d = n_load;
            end
            if (state_q == S_PULSE_HI && state_d == S_PULSE_LO) begin
                cnt_d = cnt_q + BUS_WIDTH'(1);
            end
            if ((state_d == S_PULSE_HI || state_d == S_PULSE_LO) && state_d == state_q) begin
                cyc_d = cyc_q + CW'(1);
            end
        end

        always_comb begin
            q_d  = (state_d == S_PULSE_HI);
            pe_d = (state_d == S_END);
        end

        assign q_serialized[c]     = q_q;
        assign pulses_ended[c]     = pe_q;
        assign busy[c]             = (state_q == S_LOAD) || (state_q == S_PULSE_HI) ||
                                     (state_q == S_PULSE_LO);
        assign dbg_state_o[c*3 +: 3] = state_q;
    end

endmodule

// File: tb/tb_resonant_emu_mc.sv
// Bench for resonant_emu_mc: table-driven bursts on a 3-channel instance plus hand-written
// abort, reset, i_ref-hold and saturation sequences; expectations flow through exp_q.
module tb_resonant_emu_mc;
  localparam int BW  = 10;
  localparam int NCH = 3;
  localparam int PER = 6;

  logic                clk;
  logic                rst;
  logic                start;
  logic [NCH*BW-1:0]   i_ref;
  logic [NCH-1:0]      q_ser;
  logic [NCH-1:0]      pe;
  logic [NCH-1:0]      busy;
  logic [3*NCH-1:0]    dbg;

  logic                start_s;
  logic [BW-1:0]       iref_s;
  logic                q_s;
  logic                pe_s;
  logic                busy_s;
  logic [2:0]          dbg_s;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [NCH-1:0][BW-1:0] iref;
    logic [NCH-1:0][15:0]   n;
  } vec_t;

  vec_t vecs[6];

  resonant_emu_mc #(.NUM_CH(NCH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .i_ref(i_ref),
    .q_serialized(q_ser), .pulses_ended(pe), .busy(busy), .dbg_state_o(dbg)
  );

  resonant_emu_mc #(.NUM_CH(1), .GAIN_NUM(8)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .i_ref(iref_s),
    .q_serialized(q_s), .pulses_ended(pe_s), .busy(busy_s), .dbg_state_o(dbg_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model of the pulse count at default gain.
  function automatic int model_n(input int iref);
    int n;
    n = iref / 5;
    if (n > 1023) n = 1023;
`ifdef RESONANT_EMU_Q_DROP_EN
    if (iref > 900) n = (n > 10) ? n - 10 : 0;
`endif
    return n;
  endfunction

  // driver: apply one table row, hold start for a burst plus re-latch, then compare
  task automatic run_vec(input vec_t v, input string tag);
    int end_cyc[NCH];
    int pulses[NCH];
    int shape_err[NCH];
    logic prev_q[NCH];
    int kmax;
    int n, per, t;
    logic eq, ep, eb;
    logic [31:0] e;
    kmax = 0;
    i_ref = v.iref;
    for (int c = 0; c < NCH; c++) begin
      n = int'(v.n[c]);
      exp_q.push_back({16'(1 + n*PER), 16'(n)});
      if (1 + n*PER + 3 > kmax) kmax = 1 + n*PER + 3;
      end_cyc[c] = -1; pulses[c] = 0; shape_err[c] = 0; prev_q[c] = 1'b0;
    end
    start = 1'b1;
    for (int k = 0; k <= kmax; k++) begin
      cyc();
      for (int c = 0; c < NCH; c++) begin
        n   = int'(v.n[c]);
        per = n*PER + 2;
        t   = k % per;
        eq  = (t >= 1) && (t <= n*PER) && (((t-1) % PER) < 3);
        ep  = (t == n*PER + 1);
        eb  = !ep;
        if (q_ser[c] !== eq || pe[c] !== ep || busy[c] !== eb) shape_err[c]++;
        if (end_cyc[c] < 0) begin
          if (q_ser[c] && !prev_q[c]) pulses[c]++;
          if (pe[c]) end_cyc[c] = k;
        end
        prev_q[c] = q_ser[c];
      end
    end
    start = 1'b0;
    cyc();
    check($sformatf("%s idle busy", tag), int'(busy), 0);
    check($sformatf("%s idle q", tag), int'(q_ser), 0);
    for (int c = 0; c < NCH; c++) begin
      e = exp_q.pop_front();
      check($sformatf("%s ch%0d end_cycle", tag, c), end_cyc[c], int'(e[31:16]));
      check($sformatf("%s ch%0d pulses", tag, c), pulses[c], int'(e[15:0]));
      check($sformatf("%s ch%0d shape_errors", tag, c), shape_err[c], 0);
    end
  endtask

  initial begin
    int k, cnt, end_k, n_exp;
    logic prev;
    rst = 1'b0; start = 1'b0; i_ref = '0; start_s = 1'b0; iref_s = '0;

    vecs[0].iref = {10'd0, 10'd4, 10'd100};   vecs[0].n = {16'd0, 16'd0, 16'd20};
    vecs[1].iref = {10'd0, 10'd25, 10'd10};   vecs[1].n = {16'd0, 16'd5, 16'd2};
`ifdef RESONANT_EMU_Q_DROP_EN
    vecs[2].iref = {10'd34, 10'd901, 10'd900}; vecs[2].n = {16'd6, 16'd170, 16'd180};
`else
    vecs[2].iref = {10'd34, 10'd901, 10'd900}; vecs[2].n = {16'd6, 16'd180, 16'd180};
`endif
    vecs[3].iref = {10'd14, 10'd9, 10'd5};    vecs[3].n = {16'd2, 16'd1, 16'd1};
    for (int r = 4; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) begin
        vecs[r].iref[c] = BW'($urandom_range(0, 150));
        vecs[r].n[c]    = 16'(model_n(int'(vecs[r].iref[c])));
      end
    end

    repeat (3) cyc();
    check("reset q", int'({q_ser, q_s}), 0);
    check("reset pulses_ended", int'({pe, pe_s}), 0);
    check("reset busy", int'({busy, busy_s}), 0);
    check("reset state", int'(dbg), 0);
    rst = 1'b1;
    cyc();

    for (int r = 0; r < 6; r++) run_vec(vecs[r], $sformatf("vec%0d", r));

    // i_ref moving after LOAD must not disturb the running burst, only the next one
    i_ref = '0; i_ref[BW-1:0] = 10'd10; start = 1'b1;
    k = 0; cnt = 0; end_k = -1; prev = 1'b0;
    while (k < 200 && end_k < 0) begin
      cyc();
      if (k == 3) i_ref[BW-1:0] = 10'd100;
      if (q_ser[0] && !prev) cnt++;
      prev = q_ser[0];
      if (pe[0]) end_k = k;
      k++;
    end
    check("hold end_cycle", end_k, 13);
    check("hold pulses", cnt, 2);
    cnt = 0; end_k = -1;
    while (k < 400 && end_k < 0) begin
      cyc();
      if (q_ser[0] && !prev) cnt++;
      prev = q_ser[0];
      if (pe[0]) end_k = k;
      k++;
    end
    check("relatch end_cycle", end_k, 135);
    check("relatch pulses", cnt, 20);
    start = 1'b0;
    repeat (2) cyc();

    // abort during the 9th pulse
    i_ref = '0; i_ref[BW-1:0] = 10'd100; start = 1'b1;
    for (int j = 0; j <= 50; j++) cyc();
    check("abort q before drop", int'(q_ser[0]), 1);
    start = 1'b0;
    cyc();
    check("abort q", int'(q_ser[0]), 0);
    check("abort busy", int'(busy[0]), 0);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      if (pe[0] || q_ser[0]) cnt++;
    end
    check("abort no strobe", cnt, 0);

    // asynchronous reset in the middle of a high phase
    start = 1'b1;
    for (int j = 0; j <= 2; j++) cyc();
    check("rst q before", int'(q_ser[0]), 1);
    #1 rst = 1'b0;
    #1;
    check("rst async q", int'(q_ser), 0);
    check("rst async busy", int'(busy), 0);
    check("rst async pulses_ended", int'(pe), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("rst restart LOAD busy", int'(busy[0]), 1);
    check("rst restart LOAD q", int'(q_ser[0]), 0);
    cyc();
    check("rst restart first pulse", int'(q_ser[0]), 1);
    repeat (3) cyc();
    check("rst restart gap", int'(q_ser[0]), 0);
    start = 1'b0;
    repeat (2) cyc();

    // saturation at GAIN_NUM=8
`ifdef RESONANT_EMU_Q_DROP_EN
    n_exp = 1013;
`else
    n_exp = 1023;
`endif
    iref_s = 10'd1023; start_s = 1'b1;
    k = 0; cnt = 0; end_k = -1; prev = 1'b0;
    while (k < 1023*PER + 20 && end_k < 0) begin
      cyc();
      if (q_s && !prev) cnt++;
      prev = q_s;
      if (pe_s) end_k = k;
      k++;
    end
    check("sat pulses", cnt, n_exp);
    check("sat end_cycle", end_k, 1 + n_exp*PER);
    start_s = 1'b0;
    repeat (2) cyc();

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/resonant_emu_mc.md
Name: resonant_emu_mc

Overview:
- Synthesizable, multi-channel, clocked emulator of the resonant system.
- Each channel converts a latched current reference i_ref into a burst of charge pulses on a serialized line, one pulse per Q_PER_PULSE of charge.
- Sits in the closed-loop environment opposite the Q measurement/control top: its q_serialized feeds the measurement block, and its i_ref comes from the control output.
- Replaces the untimed, single-channel behavioural emulator with a cycle-accurate, NUM_CH-wide block usable on FPGA.

Parameters:
- NUM_CH, 1: number of independent emulated channels.
- BUS_WIDTH, 10: width of each i_ref and of the pulse counters.
- Q_PER_PULSE, 5: charge represented by one pulse; must be ≥1.
- PULSE_DURATION, 3: high time of each pulse in clk cycles; must be ≥1.
- GAP_CYCLES, 3: low time after each pulse in clk cycles; must be ≥1.
- GAIN_NUM, 1: numerator of the i_ref-to-charge gain.
- GAIN_SHIFT, 0: right shift applied after multiplying by GAIN_NUM.
- DROP_THRESHOLD, 900: i_ref strictly above this triggers the Q drop (optional feature).
- DROP_PULSES, 10: pulses removed when the Q drop triggers.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: level enable shared by all channels.
- i_ref, in, NUM_CH*BUS_WIDTH: per-channel reference; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- q_serialized, out, NUM_CH: per-channel pulse train.
- pulses_ended, out, NUM_CH: one-cycle strobe marking the end of a burst.
- busy, out, NUM_CH: high while the channel is in LOAD, PULSE_HI or PULSE_LO.

Behaviour:
- Reset (rst=0, asynchronous):
  - all FSMs go to IDLE;
  - q_serialized, pulses_ended and busy are 0;
  - all counters and latched values are 0.
- Release of rst is synchronous to clk; the first evaluation happens at the next rising edge.
- Channels are fully independent copies sharing clk, rst and start.
- Per-channel FSM (states IDLE, LOAD, PULSE_HI, PULSE_LO, END):
  - IDLE: when start=1 at a clock edge, go to LOAD. That edge is cycle 0.
  - LOAD (one cycle, cycle 0): latch i_ref.
    - q_total = (i_ref * GAIN_NUM) >> GAIN_SHIFT, computed at full product width.
    - N = floor(q_total / Q_PER_PULSE), saturated to 2^BUS_WIDTH-1.
    - If N=0, go to END; otherwise go to PULSE_HI.
  - PULSE_HI: q_serialized=1 for exactly PULSE_DURATION cycles, then go to PULSE_LO.
  - PULSE_LO: q_serialized=0 for GAP_CYCLES cycles. Then, if pulses emitted equals N, go to END; otherwise go to PULSE_HI.
  - END (one cycle): pulses_ended=1.
    - If start=1, go to LOAD on the next edge and re-latch i_ref, giving a repeating burst.
    - Otherwise go to IDLE.
- Resulting timing for pulse j (0-based):
  - high during cycles 1+j*(PULSE_DURATION+GAP_CYCLES) through j*(PULSE_DURATION+GAP_CYCLES)+PULSE_DURATION;
  - END occurs in cycle 1+N*(PULSE_DURATION+GAP_CYCLES).
- q_serialized and pulses_ended are registered outputs; there are no glitches.
- i_ref changes outside LOAD have no effect on the current burst.
- start=0 while in LOAD, PULSE_HI or PULSE_LO: abort.
  - Next state is IDLE; q_serialized=0 from the next cycle.
  - No pulses_ended strobe.
  - The pulse counter clears.
- start=0 in END: pulses_ended is still asserted that cycle, then go to IDLE.
- Reset mid-burst: outputs go to 0 immediately (asynchronous); the burst is lost.

Optional Feature:
- Macro: RESONANT_EMU_Q_DROP_EN.
- Defined: in LOAD, if the latched i_ref > DROP_THRESHOLD, N = max(N - DROP_PULSES, 0), applied after saturation. This emulates the charge collapse past the instability point. If the result is 0, go to END as for N=0.
- Undefined: N is monotonic in i_ref. DROP_THRESHOLD and DROP_PULSES are ignored and no drop logic is synthesized.

Test Plan:
- Basic burst. Defaults, NUM_CH=1, i_ref=100, start held high from cycle 0. Required:
  - N=20; q_serialized high in cycles 1–3, 7–9, … through 115–117;
  - pulses_ended=1 only in cycle 121;
  - re-latch in cycle 122 and next pulse starting at cycle 123;
  - busy=0 only during cycle 121.
- Zero charge. i_ref=4. Required: N=0; no q_serialized pulse; pulses_ended in cycle 1; repeats every 2 cycles while start=1.
- Abort. i_ref=100, start dropped at cycle 50 (during the 9th pulse). Required: q_serialized=0 from cycle 51; no pulses_ended; busy=0 from cycle 51.
- Saturation and drop. GAIN_NUM=8, i_ref=1023. Required: N=1023.
  - With RESONANT_EMU_Q_DROP_EN: N=1013 (count pulses).
  - With the macro, i_ref=900 (not above the threshold): N=180 at default gain.
- Multi-channel. NUM_CH=3 with i_ref values 10, 25, 0. Required: 2, 5 and 0 pulses respectively; pulses_ended at cycles 13, 31 and 1, each independent.
- Reset. Assert rst=0 asynchronously mid-PULSE_HI. Required: q_serialized, busy and pulses_ended are 0 before the next clk edge; after release with start=1, the burst restarts from LOAD.
